alg_frame_store_ctrl: RTL

ALG_FRAME_STORE_CTRL -- requirements
Module: alg_frame_store_ctrl

---
 rtl/alg_frame_store_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/alg_frame_store_ctrl.sv
// Frame store controller: turns buffered upstream lines into one datamover S2MM
// write command per line, walking a ring of frame slots in external memory.
module alg_frame_store_ctrl #(
  parameter int unsigned CACHE_WIDTH = 29,
  parameter int unsigned IMG_STRIDE  = 1024*1025,
  parameter int unsigned LINE_STRIDE = 1024,
  parameter int unsigned NUM_LINE    = 1024,
  parameter int unsigned NUM_SLOT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] base_addr,
  input  logic        load_addr,
  input  logic        frame_start,
  input  logic [1:0]  frame_type_in,
  input  logic        line_valid,
  output logic [71:0] m_axis_s2mm_cmd_tdata,
  output logic        m_axis_s2mm_cmd_tvalid,
  input  logic        m_axis_s2mm_cmd_tready,
  input  logic [7:0]  s_axis_s2mm_sts_tdata,
  input  logic        s_axis_s2mm_sts_tvalid,
  output logic        s_axis_s2mm_sts_tready,
  output logic        frame_store,
  output logic [1:0]  frame_type,
  output logic        wr_err,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned LW = ($clog2(NUM_LINE) < 4) ? 4 : $clog2(NUM_LINE);
  localparam int unsigned SW = (NUM_SLOT > 1) ? $clog2(NUM_SLOT) : 1;
  localparam logic [LW-1:0] LAST_LINE = LW'(NUM_LINE - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SLOT - 1);
  localparam logic [31:0]   IMG_INC   = 32'(IMG_STRIDE);
  localparam logic [31:0]   LINE_INC  = 32'(LINE_STRIDE);
  localparam logic [22:0]   BTT       = 23'(LINE_STRIDE);

  typedef enum logic [2:0] {
    IDLE, WAIT_LINE, ISSUE_CMD, WAIT_STS, LINE_DONE, FRAME_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [31:0]   slot_base_q, slot_base_d;
  logic [31:0]   line_addr_q, line_addr_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [4:0]    line_pend_q, line_pend_d;
  logic          load_prev_q;
  logic          load_pend_q, load_pend_d;
  logic [1:0]    ftype_lat_q, ftype_lat_d;
  logic [1:0]    frame_type_q, frame_type_d;
  logic          frame_store_q, frame_store_d;
  logic          wr_err_q, wr_err_d;
  logic [7:0]    drop_q, drop_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [71:0]   cmd_data_q, cmd_data_d;
  logic          sts_ready_q, sts_ready_d;

  logic load_edge_c, cmd_hs_c, sts_hs_c, sts_bad_c;

  assign load_edge_c = load_addr & ~load_prev_q;
  assign cmd_hs_c    = cmd_valid_q & m_axis_s2mm_cmd_tready;
  assign sts_hs_c    = sts_ready_q & s_axis_s2mm_sts_tvalid;
  assign sts_bad_c   = (|s_axis_s2mm_sts_tdata[6:4]) | ~s_axis_s2mm_sts_tdata[7] |
                       (s_axis_s2mm_sts_tdata[3:0] != line_cnt_q[3:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      base_q        <= '0;
      slot_base_q   <= '0;
      line_addr_q   <= '0;
      slot_q        <= '0;
      line_cnt_q    <= '0;
      line_pend_q   <= '0;
      load_prev_q   <= 1'b0;
      load_pend_q   <= 1'b0;
      ftype_lat_q   <= '0;
      frame_type_q  <= '0;
      frame_store_q <= 1'b0;
      wr_err_q      <= 1'b0;
      drop_q        <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_data_q    <= '0;
      sts_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      slot_base_q   <= slot_base_d;
      line_addr_q   <= line_addr_d;
      slot_q        <= slot_d;
      line_cnt_q    <= line_cnt_d;
      line_pend_q   <= line_pend_d;
      load_prev_q   <= load_addr;
      load_pend_q   <= load_pend_d;
      ftype_lat_q   <= ftype_lat_d;
      frame_type_q  <= frame_type_d;
      frame_store_q <= frame_store_d;
      wr_err_q      <= wr_err_d;
      drop_q        <= drop_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_data_q    <= cmd_data_d;
      sts_ready_q   <= sts_ready_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    slot_base_d   = slot_base_q;
    line_addr_d   = line_addr_q;
    slot_d        = slot_q;
    line_cnt_d    = line_cnt_q;
    line_pend_d   = line_pend_q;
    load_pend_d   = load_pend_q;
    ftype_lat_d   = ftype_lat_q;
    frame_type_d  = frame_type_q;
    frame_store_d = 1'b0;
    wr_err_d      = wr_err_q;
    drop_d        = drop_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_data_d    = cmd_data_q;
    sts_ready_d   = sts_ready_q;

    // Buffered-line credit: overflow flags an error and saturates
    case ({line_valid, cmd_hs_c})
      2'b10: begin
        if (line_pend_q == 5'd31) wr_err_d = 1'b1;
        else                      line_pend_d = line_pend_q + 5'd1;
      end
      2'b01:   line_pend_d = line_pend_q - 5'd1;
      default: line_pend_d = line_pend_q;
    endcase

    if (frame_start && (state_q != IDLE) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (load_pend_q) begin
          base_d      = base_addr;
          slot_base_d = base_addr;
          slot_d      = '0;
          load_pend_d = 1'b0;
        end
        if (frame_start) begin
          ftype_lat_d = frame_type_in;
          line_cnt_d  = '0;
          line_addr_d = load_pend_q ? base_addr : slot_base_q;
          state_d     = WAIT_LINE;
        end
      end
      WAIT_LINE: begin
        if (line_pend_q != 5'd0) begin
          cmd_valid_d = 1'b1;
          cmd_data_d  = {4'd0, line_cnt_q[3:0], base_q[31:CACHE_WIDTH],
                         line_addr_q[CACHE_WIDTH-1:0], 1'b0, 1'b1, 6'd0, 1'b1, BTT};
          state_d     = ISSUE_CMD;
        end
      end
      ISSUE_CMD: begin
        if (cmd_hs_c) begin
          cmd_valid_d = 1'b0;
          sts_ready_d = 1'b1;
          state_d     = WAIT_STS;
        end
      end
      WAIT_STS: begin
        if (sts_hs_c) begin
          if (sts_bad_c) wr_err_d = 1'b1;
          sts_ready_d = 1'b0;
          // Store pulse fires the cycle right after the final status
          if (line_cnt_q == LAST_LINE) begin
            frame_store_d = 1'b1;
            frame_type_d  = ftype_lat_q;
          end
          state_d = LINE_DONE;
        end
      end
      LINE_DONE: begin
        line_cnt_d  = line_cnt_q + LW'(1);
        line_addr_d = line_addr_q + LINE_INC;
        state_d     = (line_cnt_q == LAST_LINE) ? FRAME_DONE : WAIT_LINE;
      end
      FRAME_DONE: begin
        if (slot_q == LAST_SLOT) begin
          slot_d      = '0;
          slot_base_d = base_q;
        end else begin
          slot_d      = slot_q + SW'(1);
          slot_base_d = slot_base_q + IMG_INC;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load_edge_c) load_pend_d = 1'b1;
  end

  assign m_axis_s2mm_cmd_tdata  = cmd_data_q;
  assign m_axis_s2mm_cmd_tvalid = cmd_valid_q;
  assign s_axis_s2mm_sts_tready = sts_ready_q;
  assign frame_store            = frame_store_q;
  assign frame_type             = frame_type_q;
  assign wr_err                 = wr_err_q;
  assign drop_cnt               = drop_q;

endmodule
